fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage. Holds the program counter, issues word reads on the memory block's instruction port (`imem_*`) and absorbs its one-cycle synchronous read latency. Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake. Accepts redirects (branch/jump/trap) from execute and discards any stale in-flight or buffered fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. This is the ROM region base.
- `DEPTH`, default 2: instruction FIFO entries. Power of two, ≥2.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `imem_address`  out  32  fetch address, word aligned
- `imem_enable`  out  1  read request this cycle
- `imem_data`  in  32  read data, valid the cycle after an accepted request
- `imem_wait`  in  1  request not accepted this cycle; hold address and enable
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  32  new fetch address
- `out_valid`  out  1  instruction available to decode
- `out_ready`  in  1  decode consumes this cycle
- `out_pc`  out  32  PC of presented instruction
- `out_instr`  out  32  presented instruction
- `out_fault`  out  1  misaligned fetch target (see Configuration)

## Operation
- Registers:
  - `pc`: next address to issue.
  - `inflight`: 1 bit; a request was accepted last cycle.
  - `kill`: 1 bit; drop the response that arrives this cycle.
  - FIFO of {pc, instr, fault}.
- `pop` = `out_valid & out_ready`.
- Issue condition: `count + inflight - pop < DEPTH`, and not in reset.
- Issue source:
  - `imem_enable` = issue condition.
  - `imem_address` = `redirect_valid ? redirect_pc : pc`, with bits [1:0] forced to 0.
- Request acceptance: a request is accepted when `imem_enable & !imem_wait`.
  - On acceptance, `pc` becomes issued address + 4, and `inflight` is set for the next cycle.
  - Under `imem_wait`, the address and `pc` are held.
- Response capture: when `inflight & !kill`, push {issued pc, `imem_data`, fault} into the FIFO. The issued pc is held in a register alongside `inflight`.
- Redirect (`redirect_valid` = 1):
  - FIFO is emptied this cycle; the pop and any push are ignored.
  - `out_valid` is 0 in the following cycle.
  - Any response arriving this cycle is discarded.
  - If a request is accepted this cycle, it carries `redirect_pc`. Its response is kept (`kill` stays 0 for it).
  - If the redirect-cycle request is stalled by `imem_wait`, `pc` is set to `redirect_pc` and it reissues next cycle.
- FIFO behaviour:
  - Push and pop in the same cycle are allowed, including when full.
  - Push when full cannot occur; the issue credit prevents it. Verification asserts this.
- `out_*` are driven from the FIFO head. `out_pc`, `out_instr` and `out_fault` are don't-care when `out_valid` = 0.

## Timing
- Reset values:
  - `imem_enable` = 0, `imem_address` = `RESET_PC`.
  - `out_valid` = 0, `out_fault` = 0, `out_pc` = 0, `out_instr` = 0.
  - `pc` = `RESET_PC`, `inflight` = 0, `kill` = 0, FIFO empty.
- Cycle C0 (first cycle with `reset_n` = 1): issue `RESET_PC`.
- C1: data captured.
- C2: `out_valid` = 1.
- Fetch latency is 2 cycles from issue to `out_valid`, including after a redirect.
- Sustained throughput is 1 instruction per cycle with `out_ready` held high and `DEPTH` = 2.
- Back-pressure: with `out_ready` = 0, at most `DEPTH` instructions are held, and issue stops once `count + inflight` = `DEPTH`.
- `reset_n` low mid-operation: all state returns to reset values at the next edge. Any in-flight response is dropped.
- PC wrap: 32'hFFFF_FFFC + 4 wraps to 0, with no flag raised.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - An accepted `redirect_pc` with bits [1:0] ≠ 0 is fetched from the aligned address. Its entry carries `out_fault` = 1.
  - Fetching then halts (no further issue) until the next redirect.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_pc[1:0]` is silently ignored.
  - `out_fault` is tied to 0, and the fault bit is removed from the FIFO.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_entry_t` struct {pc, instr, fault}.
  - `RESET_PC_DEFAULT` constant.
  - `XLEN` = 32.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameterised by `DEPTH`, with push/pop/flush, count and empty/full outputs.

## Test plan
- Reset release, `out_ready` = 1, ROM word n = n → `imem_address` 0,4,8,… on consecutive cycles; `out_valid` rises in C2 with `out_pc` = 0, `out_instr` = 0, then one instruction per cycle.
- `out_ready` = 0 for 10 cycles → `imem_enable` drops after 2 issues; `out_pc` held at 0; FIFO count = 2; on release, 0,4,8 are delivered in order with no gaps or duplicates.
- Redirect to 32'h0000_0100 while 2 entries are buffered and 1 is in flight → the next `out_valid` shows `out_pc` = 32'h100 exactly 2 cycles later; no stale PCs appear.
- `imem_wait` = 1 for 3 cycles on address 8 → address 8 is held; `out_pc` sequence is 0,4,8,12 with no loss.
- Redirect to 32'h0000_0102 with macro defined → `out_pc` = 32'h100, `out_fault` = 1, no further issue; with macro undefined → `out_fault` = 0 and fetch continues at 32'h104.
- `reset_n` low for 1 cycle mid-stream → `out_valid` = 0 next cycle; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, reset vector and the fetch
// buffer entry layout. When FETCH_MISALIGN_TRAP_EN is defined the entry
// carries a misaligned-target fault bit; otherwise the bit does not exist.
package riscv_pkg;

    localparam int XLEN = 32;

    // ROM region base; first instruction fetched after reset
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
        logic            fault;
`endif
    } fetch_entry_t;

    // Clear the byte offset so the address names a whole instruction word
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. DEPTH must be a power of two so
// the pointers wrap by plain overflow. Flush empties the buffer and wins over
// any push or pop in the same cycle. Push and pop may coincide when full.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_entry,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = {1'b1, {AW{1'b0}}};

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == LP_FULL);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array; data is not reset, only the pointers and count are
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // The fetch unit's issue credit must never let a push land on a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && o_full && !w_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, issues word reads to the instruction
// memory port (one-cycle synchronous latency), buffers returned words in a
// small FIFO and hands them to decode over valid/ready. A redirect flushes
// everything stale and restarts fetch at the new target in the same cycle.
//
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect target is fetched
// from its aligned word, tagged with out_fault, and fetch halts until the next
// redirect. Without it the low target bits are ignored and out_fault is 0.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    output logic        imem_enable,
    input  logic [31:0] imem_data,
    input  logic        imem_wait,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    localparam int AW = $clog2(DEPTH);
    // DEPTH expressed at the width of the occupancy sum (count + inflight)
    localparam logic [AW+1:0] LP_DEPTH = {2'b01, {AW{1'b0}}};

    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_issued_pc;
    logic            r_halt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_issued_fault;
`endif

    logic            w_redirect;
    logic [XLEN-1:0] w_raw_addr;
    logic [XLEN-1:0] w_addr;
    logic            w_fault_now;
    logic            w_issue;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic [AW+1:0]   w_occ;
    logic [AW:0]     w_count;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // A redirect presented while in reset is meaningless and ignored
    assign w_redirect = reset_n & redirect_valid;

    // The redirect target bypasses the PC register so it issues this cycle
    assign w_raw_addr = w_redirect ? redirect_pc : r_pc;
    assign w_addr     = align_word(w_raw_addr);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Only a redirect can make the raw address misaligned; a stalled
    // misaligned redirect keeps its low bits in r_pc until it is accepted
    assign w_fault_now = |w_raw_addr[1:0];
`else
    logic w_unused;
    assign w_fault_now = 1'b0;
    assign w_unused    = ^w_raw_addr[1:0];
`endif

    // Decode handshake; a redirect cancels any pop in the same cycle
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    // Entries that will occupy the FIFO after this cycle's pop, counting the
    // response still in flight; a redirect drops all of them
    assign w_occ = {1'b0, w_count}
                 + {{(AW + 1){1'b0}}, r_inflight}
                 - {{(AW + 1){1'b0}}, w_pop};

    assign w_issue = reset_n & (w_redirect | (~r_halt & (w_occ < LP_DEPTH)));

    assign imem_enable  = w_issue;
    assign imem_address = w_addr;
    assign w_accept     = w_issue & ~imem_wait;

    // Any response arriving during a redirect belongs to the old stream. With
    // a one-cycle memory no stale response can land later than that, because
    // the request accepted in the redirect cycle already carries the target.
    assign w_push = r_inflight & ~w_redirect;

    // Assemble the FIFO entry from the response and its issuing address
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = r_issued_pc;
        w_push_entry.instr = imem_data;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_push_entry.fault = r_issued_fault;
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Fetch control: next PC, outstanding-request flag and fault halt
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_pc <= w_addr + 32'd4;
            end else if (w_redirect) begin
                r_pc <= w_raw_addr;
            end
            if (w_accept) begin
                r_halt <= w_fault_now;
            end else if (w_redirect) begin
                r_halt <= 1'b0;
            end
        end
    end

    // Remember the address (and fault tag) of the accepted request for capture
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_issued_pc <= w_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_issued_fault <= w_fault_now;
`endif
        end
    end

    // Head fields read as zero when nothing is presented
    assign out_pc    = w_empty ? '0 : w_head.pc;
    assign out_instr = w_empty ? '0 : w_head.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign out_fault = ~w_empty & w_head.fault;
`else
    assign out_fault = 1'b0;
`endif

    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule
